// File: rtl/fetch_decode_pipe_pkg.sv
// Shared defaults for the single-clock fetch front end and its IF/ID register.
package fetch_decode_pipe_pkg;

  localparam int              WORD_DEF      = 64;
  localparam int              INSTR_LEN_DEF = 32;
  localparam int              PC_INC_DEF    = 4;
  localparam logic [63:0]     RESET_PC_DEF  = 64'h0;
  localparam logic [31:0]     NOP_INSTR_DEF = 32'hD503201F;
  localparam int              CNT_W_DEF     = 16;

endpackage

// File: rtl/fetch_decode_pipe_if.sv
// Fetch/decode bundle: imem bus, redirect controls and the IF/ID outputs.
// Counter signals exist only when PERF_CNT_EN is defined.
interface fetch_decode_pipe_if
  import fetch_decode_pipe_pkg::*;
#(
  parameter int WORD      = WORD_DEF,
  parameter int INSTR_LEN = INSTR_LEN_DEF
`ifdef PERF_CNT_EN
  , parameter int CNT_W   = CNT_W_DEF
`endif
);

  logic                 stall;
  logic                 flush;
  logic                 pc_src;
  logic [WORD-1:0]      branch_target;
  logic [WORD-1:0]      imem_addr;
  logic [INSTR_LEN-1:0] imem_data;
  logic                 id_valid;
  logic [INSTR_LEN-1:0] id_instr;
  logic [WORD-1:0]      id_pc;
  logic [WORD-1:0]      id_pc_plus;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0]     fetch_cnt;
  logic [CNT_W-1:0]     flush_cnt;
`endif

  modport master (
    input  stall, flush, pc_src, branch_target, imem_data,
    output imem_addr, id_valid, id_instr, id_pc, id_pc_plus
`ifdef PERF_CNT_EN
    , output fetch_cnt, flush_cnt
`endif
  );

  modport slave (
    output stall, flush, pc_src, branch_target, imem_data,
    input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus
`ifdef PERF_CNT_EN
    , input fetch_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/fetch_decode_pipe_pipe_reg.sv
// Generic register with synchronous reset, clear-to-reset-value and hold enable.
module pipe_reg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  // Clear beats enable so a squash still lands while the pipe is held.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = RST_VAL;
    end else if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_decode_pipe.sv
// Single-clock fetch front end: PC register plus IF/ID slot with stall/flush/redirect.
// Optional saturating perf counters are built when PERF_CNT_EN is defined.
module fetch_decode_pipe
  import fetch_decode_pipe_pkg::*;
#(
  parameter int                   WORD      = WORD_DEF,
  parameter int                   INSTR_LEN = INSTR_LEN_DEF,
  parameter int                   PC_INC    = PC_INC_DEF,
  parameter logic [WORD-1:0]      RESET_PC  = WORD'(RESET_PC_DEF),
  parameter logic [INSTR_LEN-1:0] NOP_INSTR = INSTR_LEN'(NOP_INSTR_DEF)
`ifdef PERF_CNT_EN
  , parameter int                 CNT_W     = CNT_W_DEF
`endif
) (
  input  logic                clk,
  input  logic                reset,
  fetch_decode_pipe_if.master bus
);

  localparam logic [WORD-1:0] INC = WORD'(PC_INC);

  logic [WORD-1:0]      pc_q;
  logic [WORD-1:0]      pc_plus;
  logic [WORD-1:0]      pc_d;
  logic                 pc_en;
  logic                 squash;
  logic                 load;
  logic [INSTR_LEN:0]   slot_q;
  logic [2*WORD-1:0]    ipc_q;

  assign pc_plus = pc_q + INC;
  assign squash  = bus.flush | bus.pc_src;
  assign load    = ~bus.stall & ~squash;
  // A redirect must move the PC even while decode is holding.
  assign pc_en   = bus.pc_src | ~bus.stall;
  assign pc_d    = bus.pc_src ? bus.branch_target : pc_plus;

  pipe_reg #(.WIDTH(WORD), .RST_VAL(RESET_PC)) u_pc (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (1'b0),
    .en_i  (pc_en),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  // IF/ID stage: valid bit and instruction squash together to a NOP bubble.
  pipe_reg #(.WIDTH(INSTR_LEN + 1), .RST_VAL({1'b0, NOP_INSTR})) u_slot (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (squash),
    .en_i  (~bus.stall),
    .d_i   ({1'b1, bus.imem_data}),
    .q_o   (slot_q)
  );

  pipe_reg #(.WIDTH(2 * WORD), .RST_VAL('0)) u_ipc (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (1'b0),
    .en_i  (load),
    .d_i   ({pc_q, pc_plus}),
    .q_o   (ipc_q)
  );

  assign bus.imem_addr  = pc_q;
  assign bus.id_valid   = slot_q[INSTR_LEN];
  assign bus.id_instr   = slot_q[INSTR_LEN-1:0];
  assign bus.id_pc      = ipc_q[2*WORD-1:WORD];
  assign bus.id_pc_plus = ipc_q[WORD-1:0];

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load) begin
      fetch_cnt_d = sat_inc(fetch_cnt_q);
    end
    if (squash) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.fetch_cnt = fetch_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Self-checking bench for fetch_decode_pipe: directed scenarios plus random traffic against a cycle model.
module tb_fetch_decode_pipe;
  import fetch_decode_pipe_pkg::*;

  localparam int          CW  = 4;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  // reference model state
  logic [63:0] m_pc, m_ipc, m_ipcp;
  logic        m_valid;
  logic [31:0] m_instr;
  int          m_fetch, m_flush;

`ifdef PERF_CNT_EN
  fetch_decode_pipe_if #(.WORD(64), .INSTR_LEN(32), .CNT_W(CW)) bus ();
  fetch_decode_pipe #(.WORD(64), .INSTR_LEN(32), .PC_INC(4), .RESET_PC(64'h0),
                      .NOP_INSTR(NOP), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );
`else
  fetch_decode_pipe_if #(.WORD(64), .INSTR_LEN(32)) bus ();
  fetch_decode_pipe #(.WORD(64), .INSTR_LEN(32), .PC_INC(4), .RESET_PC(64'h0),
                      .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );
`endif

  function automatic logic [31:0] imem_fn(input logic [63:0] a);
    if (a == 64'h0) return 32'h8B020020;
    if (a == 64'h4) return 32'hCB030041;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
  endfunction

  assign bus.imem_data = imem_fn(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; the model applies the same edge using the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_pc = 64'h0; m_valid = 1'b0; m_instr = NOP; m_ipc = 64'h0; m_ipcp = 64'h0;
      m_fetch = 0; m_flush = 0;
    end else begin
      if (bus.flush || bus.pc_src) begin
        m_valid = 1'b0; m_instr = NOP;
        if (m_flush < (1 << CW) - 1) m_flush++;
      end else if (!bus.stall) begin
        m_valid = 1'b1; m_instr = imem_fn(m_pc); m_ipc = m_pc; m_ipcp = m_pc + 64'd4;
        if (m_fetch < (1 << CW) - 1) m_fetch++;
      end
      if (bus.pc_src) m_pc = bus.branch_target;
      else if (!bus.stall) m_pc = m_pc + 64'd4;
    end
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic ps, input logic [63:0] bt);
    bus.stall = st; bus.flush = fl; bus.pc_src = ps; bus.branch_target = bt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 64'h1234);
    tick();
    total++;
    if (bus.imem_addr !== 64'h0 || bus.id_valid !== 1'b0 || bus.id_instr !== NOP ||
        bus.id_pc !== 64'h0 || bus.id_pc_plus !== 64'h0) begin
      bad++;
      $display("FAIL reset: addr=%h valid=%b instr=%h pc=%h pcp=%h want 0 0 %h 0 0",
               bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc, bus.id_pc_plus, NOP);
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_free_run();
    tick();
    total++;
    if (bus.id_valid !== 1'b1 || bus.id_instr !== 32'h8B020020 || bus.id_pc !== 64'h0 ||
        bus.id_pc_plus !== 64'h4 || bus.imem_addr !== 64'h4) begin
      bad++;
      $display("FAIL free_run1: valid=%b instr=%h pc=%h pcp=%h addr=%h want 1 8b020020 0 4 4",
               bus.id_valid, bus.id_instr, bus.id_pc, bus.id_pc_plus, bus.imem_addr);
    end
    tick();
    total++;
    if (bus.id_instr !== 32'hCB030041 || bus.id_pc !== 64'h4 || bus.id_pc_plus !== 64'h8 ||
        bus.imem_addr !== 64'h8) begin
      bad++;
      $display("FAIL free_run2: instr=%h pc=%h pcp=%h addr=%h want cb030041 4 8 8",
               bus.id_instr, bus.id_pc, bus.id_pc_plus, bus.imem_addr);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.imem_addr !== 64'h8 || bus.id_valid !== 1'b1 || bus.id_instr !== 32'hCB030041 ||
          bus.id_pc !== 64'h4 || bus.id_pc_plus !== 64'h8) begin
        bad++;
        $display("FAIL stall%0d: addr=%h valid=%b instr=%h pc=%h want 8 1 cb030041 4",
                 i, bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    total++;
    if (bus.imem_addr !== 64'hC || bus.id_pc !== 64'h8 || bus.id_instr !== imem_fn(64'h8)) begin
      bad++;
      $display("FAIL stall_resume: addr=%h pc=%h instr=%h want c 8 %h",
               bus.imem_addr, bus.id_pc, bus.id_instr, imem_fn(64'h8));
    end
  endtask

  task automatic test_redirect();
    tick();
    drive(1'b0, 1'b0, 1'b1, 64'h40);
    tick();
    total++;
    if (bus.imem_addr !== 64'h40 || bus.id_valid !== 1'b0 || bus.id_instr !== NOP ||
        bus.id_pc !== 64'hC) begin
      bad++;
      $display("FAIL redirect_squash: addr=%h valid=%b instr=%h pc=%h want 40 0 %h c",
               bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc, NOP);
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    total++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 64'h40 || bus.id_pc_plus !== 64'h44 ||
        bus.imem_addr !== 64'h44) begin
      bad++;
      $display("FAIL redirect_target: valid=%b pc=%h pcp=%h addr=%h want 1 40 44 44",
               bus.id_valid, bus.id_pc, bus.id_pc_plus, bus.imem_addr);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b0, 1'b0, 1'b1, 64'h20);
    tick();
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    tick();
    total++;
    if (bus.id_valid !== 1'b0 || bus.id_instr !== NOP || bus.imem_addr !== 64'h20) begin
      bad++;
      $display("FAIL stall_flush: valid=%b instr=%h addr=%h want 0 %h 20",
               bus.id_valid, bus.id_instr, bus.imem_addr, NOP);
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    total++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 64'h20 || bus.imem_addr !== 64'h24) begin
      bad++;
      $display("FAIL stall_flush_resume: valid=%b pc=%h addr=%h want 1 20 24",
               bus.id_valid, bus.id_pc, bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    total++;
    if (bus.id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus.id_pc_plus !== 64'h0 ||
        bus.imem_addr !== 64'h0) begin
      bad++;
      $display("FAIL wrap: pc=%h pcp=%h addr=%h want fffffffffffffffc 0 0",
               bus.id_pc, bus.id_pc_plus, bus.imem_addr);
    end
    tick();
    total++;
    if (bus.id_pc !== 64'h0 || bus.id_instr !== 32'h8B020020 || bus.imem_addr !== 64'h4) begin
      bad++;
      $display("FAIL wrap_next: pc=%h instr=%h addr=%h want 0 8b020020 4",
               bus.id_pc, bus.id_instr, bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    total++;
    if (bus.imem_addr !== 64'h0 || bus.id_valid !== 1'b0 || bus.id_pc !== 64'h0 ||
        bus.id_pc_plus !== 64'h0 || bus.id_instr !== NOP) begin
      bad++;
      $display("FAIL reset_mid: addr=%h valid=%b pc=%h pcp=%h instr=%h want 0 0 0 0 %h",
               bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_pc_plus, bus.id_instr, NOP);
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    total++;
    if (bus.id_valid !== 1'b1 || bus.id_instr !== 32'h8B020020 || bus.id_pc !== 64'h0) begin
      bad++;
      $display("FAIL reset_mid_first: valid=%b instr=%h pc=%h want 1 8b020020 0",
               bus.id_valid, bus.id_instr, bus.id_pc);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 10, {$urandom(), $urandom()});
      tick();
      total++;
      if (bus.imem_addr !== m_pc || bus.id_valid !== m_valid || bus.id_instr !== m_instr ||
          bus.id_pc !== m_ipc || bus.id_pc_plus !== m_ipcp) begin
        bad++;
        if (errs++ < 10)
          $display("FAIL random%0d: addr=%h valid=%b instr=%h pc=%h pcp=%h want %h %b %h %h %h",
                   i, bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc, bus.id_pc_plus,
                   m_pc, m_valid, m_instr, m_ipc, m_ipcp);
      end
`ifdef PERF_CNT_EN
      total++;
      if (int'(bus.fetch_cnt) !== m_fetch || int'(bus.flush_cnt) !== m_flush) begin
        bad++;
        if (errs++ < 10)
          $display("FAIL random_cnt%0d: fetch=%0d flush=%0d want %0d %0d",
                   i, bus.fetch_cnt, bus.flush_cnt, m_fetch, m_flush);
      end
`endif
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (bus.fetch_cnt !== 4'd15 || bus.flush_cnt !== 4'd0) begin
      bad++;
      $display("FAIL perf_sat: fetch=%0d flush=%0d want 15 0", bus.fetch_cnt, bus.flush_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 64'h100);
      tick();
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      tick();
    end
    total++;
    if (bus.flush_cnt !== 4'd2) begin
      bad++;
      $display("FAIL perf_flush: flush=%0d want 2", bus.flush_cnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (bus.fetch_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin
      bad++;
      $display("FAIL perf_reset: fetch=%0d flush=%0d want 0 0", bus.fetch_cnt, bus.flush_cnt);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_stall_flush();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
